ham_15_11_encoder_stream: RTL and testbench
===========================================

Name: ham_15_11_encoder_stream

Overview:
- Streaming Hamming (15,11) encoder: the transmit-side companion of ham_15_11_decoder.
- Accepts 11-bit data words on a valid/ready interface, adds 4 even-parity bits, and buffers codewords in a small FIFO.
- Drives 15-bit codewords out on a valid/ready interface.
- Optional single-bit error injection corrupts a chosen codeword position so the decoder path can be exercised in-system.

Parameters:
- DEPTH, 4, output FIFO depth in codewords; power of 2, ≥2.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  encoder can accept a word.
- in_data  in  11  data bits d[10:0].
- out_valid  out  1  out_code holds a codeword.
- out_ready  in  1  downstream accepts the codeword.
- out_code  out  15  codeword; bit i = Hamming position i+1.
- inj_req  in  1  one-cycle request to arm error injection.
- inj_pos  in  4  position to flip, 1..15; 0 means no-op.
- inj_pending  out  1  injection armed, not yet applied.
- word_cnt  out  CNT_W  count of accepted words; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - in_ready=0 during the reset cycle, 1 from the first cycle after release.
  - out_valid=0, out_code=0, inj_pending=0, word_cnt=0.
  - FIFO pointers cleared and any contents discarded, even if reset arrives mid-stream.
- Codeword layout:
  - Parity bits at positions 1, 2, 4, 8 (out_code bits 0, 1, 3, 7).
  - d0..d10 fill positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15 in ascending order.
- Parity equations:
  - p_k = XOR of all data positions whose index has bit k set.
  - Gives even parity over each covered group.
- Encoding is combinational on in_data. The codeword is written into the FIFO on the accept edge (in_valid & in_ready).
- Latency:
  - With the FIFO empty, out_valid rises the cycle after accept.
  - out_code is the FIFO head, driven from registers.
- Handshake rules:
  - Transfer occurs when valid & ready are both high at an edge.
  - out_code and out_valid stay stable while out_valid=1 and out_ready=0.
  - in_ready = !full.
  - No same-cycle pass-through when full: a pop while full frees space, and in_ready rises the next cycle.
- Simultaneous push and pop when neither empty nor full: occupancy unchanged, order preserved (strict FIFO).
- Empty FIFO: out_valid=0; out_code holds its last value (don't care).
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH. Full/empty is tracked with an occupancy counter of width log2(DEPTH)+1.
- Error-injection state machine:
  - States: IDLE, ARMED.
  - IDLE → ARMED on inj_req with inj_pos≠0; inj_pos is latched.
  - ARMED → IDLE on the next accept edge. The codeword written that edge has bit (pos−1) inverted.
  - An inj_req during ARMED re-latches the position and stays ARMED.
  - An inj_req in the same cycle as an accept does not affect that word; it applies to the next accepted word.
  - inj_pos values 1..15 are valid; 0 is ignored.
  - inj_pending = (state==ARMED).
- word_cnt increments by 1 on every accept and wraps from 2^CNT_W−1 to 0. It is not affected by injection.

Decomposition:
- Package ham_15_11_pkg:
  - Constants DATA_W=11, CODE_W=15, PAR_W=4.
  - Position map: data index → code bit.
  - Function ham_encode(d) returning the 15-bit codeword.
  - The decoder shares the position map.
- One sub-module, ham_fifo: generic synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty.
- Encoder datapath and injection state machine live in the top.

Test Plan:
- Single word after reset, in_data=11'h001 → out_code=15'h0007 one cycle later; word_cnt=1.
- Back-to-back, out_ready=1, data 11'h7FF, 11'h400, 11'h000 → out_code 15'h7FFF, 15'h408B, 15'h0000 on consecutive cycles.
- Backpressure:
  - Hold out_ready=0 and push 5 words with DEPTH=4.
  - in_ready drops after the 4th accept; out_code stays 15'h0007 (first word) and stable.
  - Release out_ready: 4 words drain in order, then the 5th is accepted.
- Injection:
  - inj_req with inj_pos=3, then send 11'h001 → out_code=15'h0003; inj_pending 1→0.
  - The next word 11'h001 → 15'h0007.
  - inj_pos=0 → no arm.
- Reset mid-operation: FIFO holds 3 words, rst_n=0 for 1 cycle → out_valid=0, word_cnt=0, inj_pending=0; the old words never appear.
- Counter wrap: with CNT_W=4, 17 accepts → word_cnt=1.

Source files
------------

// File: rtl/ham_15_11_encoder_stream_pkg.sv
// Shared Hamming (15,11) definitions: widths, data-to-code position map and
// the encode function. The decoder uses the same position map.
package ham_15_11_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int PAR_W  = 4;

  // Hamming position (1-based) of each data bit d0..d10.
  localparam logic [3:0] DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // out_code bit index of parity p_k (positions 1, 2, 4, 8).
  localparam logic [3:0] PAR_BIT [PAR_W] = '{4'd0, 4'd1, 4'd3, 4'd7};

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_t;

  function automatic logic [CODE_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              p;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c[DATA_POS[i] - 4'd1] = d[i];
    end
    for (int k = 0; k < PAR_W; k++) begin
      p = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
        if (DATA_POS[i][k]) p = p ^ d[i];
      end
      c[PAR_BIT[k]] = p;
    end
    return c;
  endfunction

endpackage

// File: rtl/ham_15_11_encoder_stream_fifo.sv
// Generic synchronous FIFO with registered storage; the head entry is read
// straight out of the storage registers.
module ham_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ham_15_11_encoder_stream.sv
// Streaming Hamming (15,11) encoder with output FIFO, accepted-word counter
// and one-shot single-bit error injection.
module ham_15_11_encoder_stream
  import ham_15_11_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  input  logic              inj_req,
  input  logic [3:0]        inj_pos,
  output logic              inj_pending,
  output logic [CNT_W-1:0]  word_cnt
);

  inj_state_t        r_inj_state;
  logic [3:0]        r_inj_pos;
  logic              r_rdy_en;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic [CODE_W-1:0] w_flip;
  logic [CODE_W-1:0] w_code;

  assign in_ready    = r_rdy_en & ~w_full;
  assign out_valid   = ~w_empty;
  assign w_accept    = in_valid & in_ready;
  assign inj_pending = (r_inj_state == INJ_ARMED);
  assign word_cnt    = r_word_cnt;

  // r_inj_pos is never 0 while armed, so pos-1 is a valid bit index.
  assign w_flip = (r_inj_state == INJ_ARMED) ? (CODE_W'(1) << (r_inj_pos - 4'd1)) : '0;
  assign w_code = ham_encode(in_data) ^ w_flip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy_en   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // A new request wins over the accept edge: the word accepted now uses the
  // old arming, and the freshly latched position applies to the next word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inj_state <= INJ_IDLE;
      r_inj_pos   <= '0;
    end else if (inj_req && (inj_pos != 4'd0)) begin
      r_inj_state <= INJ_ARMED;
      r_inj_pos   <= inj_pos;
    end else if (w_accept) begin
      r_inj_state <= INJ_IDLE;
    end
  end

  ham_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_accept),
    .pop   (out_ready),
    .wdata (w_code),
    .rdata (out_code),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_ham_15_11_encoder_stream.sv
// Directed bench for the Hamming (15,11) stream encoder with an expected-code
// queue checked by an independent output monitor.
module tb_ham_15_11_encoder_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;
  logic        inj_req;
  logic [3:0]  inj_pos;
  logic        inj_pending;
  logic [3:0]  word_cnt;

  logic [14:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;

  always #5 clk = ~clk;

  ham_15_11_encoder_stream #(.DEPTH(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .inj_req     (inj_req),
    .inj_pos     (inj_pos),
    .inj_pending (inj_pending),
    .word_cnt    (word_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Holds in_valid until accepted; records the expected code on the accept edge.
  task automatic send(input logic [10:0] d, input logic [14:0] e);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stuck at 0 for data 0x%0h", d);
        break;
      end
    end
    if (in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic arm(input logic [3:0] pos);
    inj_req = 1'b1;
    inj_pos = pos;
    @(posedge clk);
    #1 inj_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: a transfer seen at this negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got 0x%0h with nothing expected", out_code);
      end else begin
        chk("out_code", {17'd0, out_code}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    inj_req   = 1'b0;
    inj_pos   = '0;
    step(2);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_code", out_code, 0);
    chk("reset_inj_pending", inj_pending, 0);
    chk("reset_word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    step(1);
    chk("in_ready_after_release", in_ready, 1);

    // Single word: output valid the cycle after accept.
    send(11'h001, 15'h0007);
    chk("latency_out_valid", out_valid, 1);
    chk("latency_out_code", out_code, 15'h0007);
    chk("word_cnt_1", word_cnt, 1);
    wait_drain();

    // Back-to-back with out_ready high: one pop per cycle.
    p0 = pops;
    send(11'h7FF, 15'h7FFF);
    send(11'h400, 15'h408B);
    send(11'h000, 15'h0000);
    step(3);
    chk("b2b_pop_count", pops - p0, 3);
    wait_drain();

    // Backpressure: fill four slots, the fifth waits for space.
    out_ready = 1'b0;
    send(11'h001, 15'h0007);
    send(11'h002, 15'h0019);
    send(11'h003, 15'h001E);
    send(11'h004, 15'h002A);
    fork
      send(11'h005, 15'h002D);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_code", out_code, 15'h0007);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Injection at position 3 flips code bit 2, once.
    arm(4'd3);
    chk("inj_pending_armed", inj_pending, 1);
    send(11'h001, 15'h0003);
    chk("inj_pending_cleared", inj_pending, 0);
    send(11'h001, 15'h0007);
    arm(4'd0);
    chk("inj_pos0_no_arm", inj_pending, 0);
    send(11'h001, 15'h0007);
    // Request coincident with an accept applies to the following word.
    inj_req = 1'b1;
    inj_pos = 4'd1;
    send(11'h001, 15'h0007);
    inj_req = 1'b0;
    chk("inj_same_cycle_pending", inj_pending, 1);
    send(11'h001, 15'h0006);
    wait_drain();

    // Reset with three words buffered and injection armed.
    out_ready = 1'b0;
    send(11'h7FF, 15'h7FFF);
    send(11'h400, 15'h408B);
    send(11'h002, 15'h0019);
    arm(4'd5);
    rst_n = 1'b0;
    exp_q.delete();
    step(1);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_inj_pending", inj_pending, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(5);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Counter wrap: 17 accepts on a 4-bit counter leaves 1.
    for (int i = 0; i < 17; i++) send(11'h000, 15'h0000);
    chk("word_cnt_wrap", word_cnt, 1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
